// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared lc3b opcode, nzp and write-back stage types
package lc3b_types;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   typedef logic [2:0] lc3b_nzp;

   typedef enum logic [1:0] {
      WB_IDLE,
      WB_WAIT,
      WB_COMMIT
   } lc3b_wb_state_t;

   // regfilemux_sel encodings; every value from RFMUX_BYTE upward is a byte load
   localparam logic [2:0] RFMUX_ALU   = 3'd0;
   localparam logic [2:0] RFMUX_WORD  = 3'd1;
   localparam logic [2:0] RFMUX_PC    = 3'd2;
   localparam logic [2:0] RFMUX_PC_BR = 3'd3;
   localparam logic [2:0] RFMUX_BYTE  = 3'd4;

endpackage

// File: rtl/lc3b_wb_align.sv
// rtl/lc3b_wb_align.sv - byte lane select and sign/zero extension for byte loads
module lc3b_wb_align #(
   parameter int WIDTH     = 16,
   parameter bit SEXT_BYTE = 1'b0
) (
   input  logic [15:0]      lane_data,
   input  logic             lane_sel,
   output logic [WIDTH-1:0] byte_ext
);

   logic [7:0] byte_val;

   always_comb begin
      byte_val = lane_sel ? lane_data[15:8] : lane_data[7:0];
      byte_ext = {{(WIDTH-8){SEXT_BYTE & byte_val[7]}}, byte_val};
   end

endmodule

// File: rtl/lc3b_writeback_unit.sv
// rtl/lc3b_writeback_unit.sv - handshaked lc3b write-back stage
// Waits on dmem for loads, commits to the regfile, owns CC and resolves branches.
module lc3b_writeback_unit
   import lc3b_types::*;
#(
   parameter int WIDTH       = 16,
   parameter int NREGS       = 8,
   parameter int MEM_TIMEOUT = 64,
   parameter int SEXT_BYTE   = 0,
   localparam int DW         = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  lc3b_opcode       opcode,
   input  logic [DW-1:0]    dest,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] pc_br,
   input  logic [WIDTH-1:0] alu_out,
   input  logic [WIDTH-1:0] dmem_address,
   input  logic [2:0]       regfilemux_sel,
   input  logic             load_cc,
   input  logic             load_rf,
   input  logic             mem_read,
   input  logic             dmem_resp,
   input  logic [WIDTH-1:0] dmem_rdata,
   output logic             rf_we,
   output logic [DW-1:0]    rf_dest,
   output logic [WIDTH-1:0] rf_wdata,
   output lc3b_nzp          cc_out,
   output logic             branch_enable,
   output logic [WIDTH-1:0] branch_target,
   output logic             mem_error
);

   localparam int CW = $clog2(MEM_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

   lc3b_wb_state_t   state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   lc3b_opcode       op_q, op_d;
   logic [DW-1:0]    dest_q, dest_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pc_br_q, pc_br_d;
   logic [WIDTH-1:0] alu_q, alu_d;
   logic             addr0_q, addr0_d;
   logic [2:0]       sel_q, sel_d;
   logic             load_cc_q, load_cc_d;
   logic             load_rf_q, load_rf_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             rf_we_q, rf_we_d;
   logic [DW-1:0]    rf_dest_q, rf_dest_d;
   logic [WIDTH-1:0] rf_wdata_q, rf_wdata_d;
   lc3b_nzp          cc_q, cc_d;
   logic             br_en_q, br_en_d;
   logic [WIDTH-1:0] br_tgt_q, br_tgt_d;
   logic             mem_err_q, mem_err_d;

   logic [WIDTH-1:0] byte_data;
   logic [WIDTH-1:0] sel_data;
   lc3b_nzp          new_cc;
   logic             br_taken;
   logic             unused_addr_hi;

   assign unused_addr_hi = ^dmem_address[WIDTH-1:1];

   lc3b_wb_align #(
      .WIDTH     (WIDTH),
      .SEXT_BYTE (SEXT_BYTE != 0)
   ) u_align (
      .lane_data (rdata_q[15:0]),
      .lane_sel  (addr0_q),
      .byte_ext  (byte_data)
   );

   always_comb begin
      sel_data = byte_data;
      if (sel_q < RFMUX_BYTE) begin
         case (sel_q)
            RFMUX_ALU:   sel_data = alu_q;
            RFMUX_WORD:  sel_data = rdata_q;
            RFMUX_PC:    sel_data = pc_q;
            RFMUX_PC_BR: sel_data = pc_br_q;
            default:     sel_data = byte_data;
         endcase
      end
   end

   // Branch resolution deliberately reads cc_q, the value before this commit's update
   always_comb begin
      if (sel_data[WIDTH-1])
         new_cc = 3'b100;
      else if (sel_data == '0)
         new_cc = 3'b010;
      else
         new_cc = 3'b001;
      br_taken = |(dest_q[2:0] & cc_q);
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      dest_d     = dest_q;
      pc_d       = pc_q;
      pc_br_d    = pc_br_q;
      alu_d      = alu_q;
      addr0_d    = addr0_q;
      sel_d      = sel_q;
      load_cc_d  = load_cc_q;
      load_rf_d  = load_rf_q;
      rdata_d    = rdata_q;
      rf_we_d    = 1'b0;
      rf_dest_d  = rf_dest_q;
      rf_wdata_d = rf_wdata_q;
      cc_d       = cc_q;
      br_en_d    = 1'b0;
      br_tgt_d   = br_tgt_q;
      mem_err_d  = mem_err_q;
      in_ready   = (state_q == WB_IDLE);

      case (state_q)
         WB_IDLE: begin
            if (in_valid) begin
               op_d      = opcode;
               dest_d    = dest;
               pc_d      = pc;
               pc_br_d   = pc_br;
               alu_d     = alu_out;
               addr0_d   = dmem_address[0];
               sel_d     = regfilemux_sel;
               load_cc_d = load_cc;
               load_rf_d = load_rf;
               rdata_d   = '0;
               cnt_d     = '0;
               state_d   = mem_read ? WB_WAIT : WB_COMMIT;
            end
         end
         WB_WAIT: begin
            if (dmem_resp) begin
               rdata_d = dmem_rdata;
               state_d = WB_COMMIT;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d   = '0;
               mem_err_d = 1'b1;
               state_d   = WB_COMMIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WB_COMMIT: begin
            state_d    = WB_IDLE;
            rf_we_d    = load_rf_q;
            rf_dest_d  = dest_q;
            rf_wdata_d = sel_data;
            br_tgt_d   = pc_br_q;
            if (load_cc_q)
               cc_d = new_cc;
            br_en_d = ((op_q == op_br) && br_taken) || (op_q == op_jmp) ||
                      (op_q == op_jsr) || (op_q == op_trap);
         end
         default: state_d = WB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= WB_IDLE;
         cnt_q      <= '0;
         op_q       <= op_br;
         dest_q     <= '0;
         pc_q       <= '0;
         pc_br_q    <= '0;
         alu_q      <= '0;
         addr0_q    <= 1'b0;
         sel_q      <= RFMUX_ALU;
         load_cc_q  <= 1'b0;
         load_rf_q  <= 1'b0;
         rdata_q    <= '0;
         rf_we_q    <= 1'b0;
         rf_dest_q  <= '0;
         rf_wdata_q <= '0;
         cc_q       <= 3'b010;
         br_en_q    <= 1'b0;
         br_tgt_q   <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         dest_q     <= dest_d;
         pc_q       <= pc_d;
         pc_br_q    <= pc_br_d;
         alu_q      <= alu_d;
         addr0_q    <= addr0_d;
         sel_q      <= sel_d;
         load_cc_q  <= load_cc_d;
         load_rf_q  <= load_rf_d;
         rdata_q    <= rdata_d;
         rf_we_q    <= rf_we_d;
         rf_dest_q  <= rf_dest_d;
         rf_wdata_q <= rf_wdata_d;
         cc_q       <= cc_d;
         br_en_q    <= br_en_d;
         br_tgt_q   <= br_tgt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   assign rf_we         = rf_we_q;
   assign rf_dest       = rf_dest_q;
   assign rf_wdata      = rf_wdata_q;
   assign cc_out        = cc_q;
   assign branch_enable = br_en_q;
   assign branch_target = br_tgt_q;
   assign mem_error     = mem_err_q;

endmodule
